id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/id_stage_if.sv | 23 ++
 rtl/regfile.sv | 31 +++
 rtl/id_stage.sv | 95 +++++++++
 tb/tb_id_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for decode and execute: opcodes, funct codes, field positions, NOP.
// Used by id_stage (optional same-edge write-back bypass: ID_WB_BYPASS_EN) and the EXE stage.
package pipe_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;
    typedef logic [4:0] reg_addr_t;

    localparam opcode_t OP_RTYPE = 6'd0;
    localparam opcode_t OP_J     = 6'd2;
    localparam opcode_t OP_BEQ   = 6'd4;
    localparam opcode_t OP_ADDI  = 6'd8;
    localparam opcode_t OP_LW    = 6'd35;
    localparam opcode_t OP_SW    = 6'd43;

    localparam funct_t FN_ADD = 6'h20;
    localparam funct_t FN_SUB = 6'h22;
    localparam funct_t FN_AND = 6'h24;
    localparam funct_t FN_OR  = 6'h25;
    localparam funct_t FN_SLT = 6'h2A;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    localparam logic [31:0] NOP = 32'd0;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input opcode_t op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch/write-back/branch inputs and the registered EXE-side outputs.
interface id_stage_if;
    logic        [31:0] Instruction_ID;
    logic               Wb_en;
    logic        [4:0]  Wb_addr;
    logic signed [31:0] Wb_data;
    logic               branch;
    logic        [31:0] Instruction_EXE;
    logic signed [31:0] Read_data1;
    logic signed [31:0] Read_data2;
    logic signed [31:0] Sign_extend;
    logic               stall;

    modport master (
        output Instruction_ID, Wb_en, Wb_addr, Wb_data, branch,
        input  Instruction_EXE, Read_data1, Read_data2, Sign_extend, stall
    );

    modport slave (
        input  Instruction_ID, Wb_en, Wb_addr, Wb_data, branch,
        output Instruction_EXE, Read_data1, Read_data2, Sign_extend, stall
    );
endinterface

// File: rtl/regfile.sv
// 32-entry GPR file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module regfile
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  reg_addr_t                ra1,
    input  reg_addr_t                ra2,
    input  logic                     we,
    input  reg_addr_t                wa,
    input  logic signed [DATA_W-1:0] wd,
    output logic signed [DATA_W-1:0] rd1,
    output logic signed [DATA_W-1:0] rd2
);

    logic signed [DATA_W-1:0] gpr [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            gpr[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : gpr[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : gpr[ra2];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register read, sign extension, load-use stall and flush bubbles.
// Optional ID_WB_BYPASS_EN: a same-edge write-back to rs/rt is captured instead of the old GPR value.
module id_stage
    import pipe_pkg::*;
(
    input logic        clk,
    input logic        reset,
    id_stage_if.slave  bus
);

    localparam int DATA_W = 32;

    reg_addr_t                rs_p0;
    reg_addr_t                rt_p0;
    opcode_t                  op_p0;
    opcode_t                  ex_op;
    reg_addr_t                ex_rt;
    logic signed [DATA_W-1:0] rf_rd1_p0;
    logic signed [DATA_W-1:0] rf_rd2_p0;
    logic signed [DATA_W-1:0] rd1_p0;
    logic signed [DATA_W-1:0] rd2_p0;
    logic signed [DATA_W-1:0] sext_p0;
    logic                     stall_p0;
    logic                     bubble_p0;

    logic        [31:0]       instr_p1;
    logic signed [DATA_W-1:0] rd1_p1;
    logic signed [DATA_W-1:0] rd2_p1;
    logic signed [DATA_W-1:0] sext_p1;

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Stage p0: decode fields, register read, hazard detection
    assign rs_p0 = bus.Instruction_ID[RS_LSB +: 5];
    assign rt_p0 = bus.Instruction_ID[RT_LSB +: 5];
    assign op_p0 = bus.Instruction_ID[OP_LSB +: 6];
    assign ex_op = instr_p1[OP_LSB +: 6];
    assign ex_rt = instr_p1[RT_LSB +: 5];

    regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs_p0),
        .ra2   (rt_p0),
        .we    (bus.Wb_en),
        .wa    (bus.Wb_addr),
        .wd    (bus.Wb_data),
        .rd1   (rf_rd1_p0),
        .rd2   (rf_rd2_p0)
    );

`ifdef ID_WB_BYPASS_EN
    assign rd1_p0 = (bus.Wb_en && bus.Wb_addr != 5'd0 && bus.Wb_addr == rs_p0) ? bus.Wb_data : rf_rd1_p0;
    assign rd2_p0 = (bus.Wb_en && bus.Wb_addr != 5'd0 && bus.Wb_addr == rt_p0) ? bus.Wb_data : rf_rd2_p0;
`else
    assign rd1_p0 = rf_rd1_p0;
    assign rd2_p0 = rf_rd2_p0;
`endif

    assign sext_p0 = sign_ext(bus.Instruction_ID[IMM_LSB +: IMM_W]);

    // A nop in decode never stalls, even though its rs/rt fields read as r0.
    assign stall_p0 = (ex_op == OP_LW) && (ex_rt != 5'd0) && (bus.Instruction_ID != NOP) &&
                      ((ex_rt == rs_p0) || ((ex_rt == rt_p0) && reads_rt(op_p0)));
    assign bubble_p0 = bus.branch || stall_p0;

    // Stage p1: ID/EXE pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_p1 <= NOP;
            rd1_p1   <= '0;
            rd2_p1   <= '0;
            sext_p1  <= '0;
        end else if (bubble_p0) begin
            instr_p1 <= NOP;
            rd1_p1   <= '0;
            rd2_p1   <= '0;
            sext_p1  <= '0;
        end else begin
            instr_p1 <= bus.Instruction_ID;
            rd1_p1   <= rd1_p0;
            rd2_p1   <= rd2_p0;
            sext_p1  <= sext_p0;
        end
    end

    assign bus.Instruction_EXE = instr_p1;
    assign bus.Read_data1      = rd1_p1;
    assign bus.Read_data2      = rd2_p1;
    assign bus.Sign_extend     = sext_p1;
    assign bus.stall           = stall_p0;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register read, sign extension, load-use stall, flush, r0, bypass, reset.
module tb_id_stage;
    import pipe_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    id_stage_if bus ();

    id_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests++;
        if ({bus.Instruction_EXE, bus.Read_data1, bus.Read_data2, bus.Sign_extend} !== 128'd0) begin
            fails++;
            $display("FAIL %s: got instr=%h rd1=%h rd2=%h sext=%h expected all 0", name,
                     bus.Instruction_EXE, bus.Read_data1, bus.Read_data2, bus.Sign_extend);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        #1;
        tests++;
        if (bus.stall !== exp) begin
            fails++;
            $display("FAIL %s: got stall=%b expected %b", name, bus.stall, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.Wb_en = 1'b1; bus.Wb_addr = addr; bus.Wb_data = data;
        tick();
        bus.Wb_en = 1'b0; bus.Wb_addr = 5'd0; bus.Wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.Instruction_ID = rtype(5'd1, 5'd2, 5'd3, FN_ADD);
        bus.Wb_en = 1'b0; bus.Wb_addr = '0; bus.Wb_data = '0; bus.branch = 1'b0;
        #2;
        check_zero_outputs("reset_outputs");
        check_stall("reset_stall", 1'b0);
        tick();
        check_zero_outputs("reset_held_over_edge");
        bus.Instruction_ID = NOP;
        reset = 1'b1;
    endtask

    task automatic test_read_add();
        wb_write(5'd5, 32'h0000_0007);
        bus.Instruction_ID = 32'h00A0_1820;
        check_stall("add_no_stall", 1'b0);
        tick();
        check32("add_instr_exe", bus.Instruction_EXE, 32'h00A0_1820);
        check32("add_rd1", bus.Read_data1, 32'h0000_0007);
        check32("add_rd2", bus.Read_data2, 32'h0000_0000);
        check32("add_rtype_sext", bus.Sign_extend, 32'h0000_1820);
        bus.Instruction_ID = NOP;
        tick();
        check_zero_outputs("nop_bubble");
    endtask

    task automatic test_sign_extend();
        bus.Instruction_ID = itype(OP_ADDI, 5'd5, 5'd1, 16'hFFFC);
        tick();
        check32("sext_neg", bus.Sign_extend, 32'hFFFF_FFFC);
        check32("sext_neg_rd1", bus.Read_data1, 32'h0000_0007);
        bus.Instruction_ID = itype(OP_ADDI, 5'd0, 5'd1, 16'h7FFF);
        tick();
        check32("sext_pos", bus.Sign_extend, 32'h0000_7FFF);
        check32("sext_pos_instr", bus.Instruction_EXE, 32'h2001_7FFF);
    endtask

    task automatic test_load_use();
        bus.Instruction_ID = 32'h8C24_0000;
        tick();
        check32("lw_in_exe", bus.Instruction_EXE, 32'h8C24_0000);
        bus.Instruction_ID = 32'h0081_1020;
        check_stall("lu_rs_stall", 1'b1);
        tick();
        check_zero_outputs("lu_bubble");
        check_stall("lu_released", 1'b0);
        tick();
        check32("lu_add_issued", bus.Instruction_EXE, 32'h0081_1020);
        bus.Instruction_ID = 32'h8C24_0000;
        tick();
        bus.Instruction_ID = itype(OP_SW, 5'd1, 5'd4, 16'd0);
        check_stall("lu_sw_rt_stall", 1'b1);
        bus.Instruction_ID = itype(OP_ADDI, 5'd1, 5'd4, 16'd1);
        check_stall("lu_addi_rt_dest", 1'b0);
        bus.Instruction_ID = NOP;
        check_stall("lu_nop_no_stall", 1'b0);
        tick();
        bus.Instruction_ID = itype(OP_LW, 5'd1, 5'd0, 16'd0);
        tick();
        bus.Instruction_ID = rtype(5'd0, 5'd0, 5'd2, FN_ADD);
        check_stall("lu_lw_r0_no_stall", 1'b0);
        tick();
    endtask

    task automatic test_branch_flush();
        bus.Instruction_ID = 32'h8C24_0000;
        tick();
        bus.Instruction_ID = 32'h0081_1020;
        bus.branch = 1'b1;
        check_stall("br_stall_also_high", 1'b1);
        tick();
        check_zero_outputs("br_flush_over_stall");
        bus.Instruction_ID = itype(OP_ADDI, 5'd5, 5'd8, 16'd5);
        tick();
        check_zero_outputs("br_flush_valid");
        bus.branch = 1'b0;
        wb_write(5'd0, 32'h0000_DEAD);
        bus.Instruction_ID = rtype(5'd0, 5'd0, 5'd3, FN_OR);
        tick();
        check32("r0_rd1", bus.Read_data1, 32'h0);
        check32("r0_rd2", bus.Read_data2, 32'h0);
    endtask

    task automatic test_wb_bypass();
        wb_write(5'd6, 32'h0000_0011);
        bus.Instruction_ID = rtype(5'd6, 5'd6, 5'd7, FN_ADD);
        bus.Wb_en = 1'b1; bus.Wb_addr = 5'd6; bus.Wb_data = 32'h0000_0055;
        tick();
        bus.Wb_en = 1'b0; bus.Wb_addr = 5'd0; bus.Wb_data = '0;
`ifdef ID_WB_BYPASS_EN
        check32("byp_rd1", bus.Read_data1, 32'h0000_0055);
        check32("byp_rd2", bus.Read_data2, 32'h0000_0055);
`else
        check32("byp_rd1_old", bus.Read_data1, 32'h0000_0011);
        check32("byp_rd2_old", bus.Read_data2, 32'h0000_0011);
`endif
        tick();
        check32("byp_rd1_after", bus.Read_data1, 32'h0000_0055);
    endtask

    task automatic test_reset_midstream();
        wb_write(5'd9, 32'h0000_1234);
        bus.Instruction_ID = rtype(5'd9, 5'd0, 5'd3, FN_ADD);
        tick();
        check32("mid_pre_rd1", bus.Read_data1, 32'h0000_1234);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("mid_async_clear");
        #2;
        reset = 1'b1;
        tick();
        check32("mid_first_capture", bus.Instruction_EXE, rtype(5'd9, 5'd0, 5'd3, FN_ADD));
        check32("mid_gpr_cleared", bus.Read_data1, 32'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        tick();
        test_read_add();
        test_sign_extend();
        test_load_use();
        test_branch_flush();
        test_wb_bypass();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
